// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with a 2-bit saturating
// direction counter per entry, combinational lookup on the fetch PC and
// registered training from the execute stage. Also keeps a saturating
// count of resolved mispredictions.
module branch_predictor #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ENTRIES    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fetch_pc,
  output logic                  predict_valid,
  output logic                  predict_taken,
  output logic [DATA_WIDTH-1:0] predict_target,
  input  logic                  update_en,
  input  logic [DATA_WIDTH-1:0] update_pc,
  input  logic                  update_taken,
  input  logic [DATA_WIDTH-1:0] update_target,
  input  logic                  update_mispredict,
  output logic [31:0]           mispredict_count
);

  localparam int unsigned IDX_BITS = $clog2(ENTRIES);
  localparam int unsigned TAG_BITS = DATA_WIDTH - IDX_BITS - 2;

  // Direction counter encodings
  localparam logic [1:0] CTR_STRONG_NT = 2'b00;
  localparam logic [1:0] CTR_WEAK_NT   = 2'b01;
  localparam logic [1:0] CTR_WEAK_T    = 2'b10;
  localparam logic [1:0] CTR_STRONG_T  = 2'b11;

  // Entry storage; only valid and ctr carry reset state
  logic                  valid_q  [ENTRIES];
  logic [1:0]            ctr_q    [ENTRIES];
  logic [TAG_BITS-1:0]   tag_q    [ENTRIES];
  logic [DATA_WIDTH-1:0] target_q [ENTRIES];

  // Address split for lookup and update ports (pc[1:0] is ignored)
  logic [IDX_BITS-1:0] fetch_idx;
  logic [TAG_BITS-1:0] fetch_tag;
  logic [IDX_BITS-1:0] upd_idx;
  logic [TAG_BITS-1:0] upd_tag;
  logic                unused_pc_bits;

  assign fetch_idx      = fetch_pc[IDX_BITS+1:2];
  assign fetch_tag      = fetch_pc[DATA_WIDTH-1:IDX_BITS+2];
  assign upd_idx        = update_pc[IDX_BITS+1:2];
  assign upd_tag        = update_pc[DATA_WIDTH-1:IDX_BITS+2];
  assign unused_pc_bits = ^{fetch_pc[1:0], update_pc[1:0]};

  // Lookup path
  logic fetch_hit;

  // Combinational BTB lookup; reads pre-update contents (no bypass)
  always_comb begin
    fetch_hit      = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    predict_valid  = fetch_hit;
    predict_taken  = fetch_hit && ctr_q[fetch_idx][1];
    predict_target = fetch_hit ? target_q[fetch_idx] : '0;
  end

  // Update path decode
  logic       upd_hit;
  logic       upd_write_entry;
  logic [1:0] upd_ctr_cur;
  logic [1:0] upd_ctr_next;

  // Next counter value for the trained entry
  always_comb begin
    upd_hit         = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    upd_ctr_cur     = ctr_q[upd_idx];
    upd_ctr_next    = upd_ctr_cur;
    upd_write_entry = 1'b0;
    if (update_en) begin
      if (upd_hit) begin
        upd_write_entry = 1'b1;
        if (update_taken) begin
          upd_ctr_next = (upd_ctr_cur == CTR_STRONG_T) ? CTR_STRONG_T
                                                       : upd_ctr_cur + 2'd1;
        end else begin
          upd_ctr_next = (upd_ctr_cur == CTR_STRONG_NT) ? CTR_STRONG_NT
                                                        : upd_ctr_cur - 2'd1;
        end
      end else if (update_taken) begin
        // Taken miss allocates (or evicts an aliasing entry); not-taken misses never allocate
        upd_write_entry = 1'b1;
        upd_ctr_next    = CTR_WEAK_T;
      end
    end
  end

  // BTB array state; tag/target are left unreset since valid masks them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= CTR_WEAK_NT;
      end
    end else if (upd_write_entry) begin
      valid_q[upd_idx] <= 1'b1;
      ctr_q[upd_idx]   <= upd_ctr_next;
      if (update_taken) begin
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= update_target;
      end
    end
  end

  // Saturating misprediction counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mispredict_count <= '0;
    end else if (update_en && update_mispredict && (mispredict_count != '1)) begin
      mispredict_count <= mispredict_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table,
// hand-written reset sequence, and randomized traffic against a
// behavioural BTB model.
module tb_branch_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fetch_pc;
  logic        predict_valid;
  logic        predict_taken;
  logic [31:0] predict_target;
  logic        update_en;
  logic [31:0] update_pc;
  logic        update_taken;
  logic [31:0] update_target;
  logic        update_mispredict;
  logic [31:0] mispredict_count;

  int checks   = 0;
  int failures = 0;

  branch_predictor #(.DATA_WIDTH(32), .ENTRIES(16)) dut (
    .clk               (clk),
    .rst               (rst),
    .fetch_pc          (fetch_pc),
    .predict_valid     (predict_valid),
    .predict_taken     (predict_taken),
    .predict_target    (predict_target),
    .update_en         (update_en),
    .update_pc         (update_pc),
    .update_taken      (update_taken),
    .update_target     (update_target),
    .update_mispredict (update_mispredict),
    .mispredict_count  (mispredict_count)
  );

  always #5 clk = ~clk;

  // Behavioural model: 16 entries, index = (pc/4)%16, tag = pc/64
  bit          m_valid  [16];
  int          m_ctr    [16];
  logic [31:0] m_tag    [16];
  logic [31:0] m_target [16];
  longint      m_count;

  function automatic int unsigned m_idx(input logic [31:0] pc);
    return (pc / 4) % 16;
  endfunction

  function automatic logic [31:0] m_tg(input logic [31:0] pc);
    return pc / 64;
  endfunction

  function automatic bit m_hit(input logic [31:0] pc);
    return m_valid[m_idx(pc)] && (m_tag[m_idx(pc)] == m_tg(pc));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0;
      m_ctr[i]   = 1;
    end
    m_count = 0;
  endtask

  task automatic model_update(input bit ue, input logic [31:0] pc, input bit t,
                              input logic [31:0] tgt, input bit mp);
    int unsigned k;
    k = m_idx(pc);
    if (ue) begin
      if (m_hit(pc)) begin
        if (t) begin
          m_ctr[k]    = (m_ctr[k] + 1 > 3) ? 3 : m_ctr[k] + 1;
          m_target[k] = tgt;
        end else begin
          m_ctr[k] = (m_ctr[k] - 1 < 0) ? 0 : m_ctr[k] - 1;
        end
      end else if (t) begin
        m_valid[k]  = 1;
        m_tag[k]    = m_tg(pc);
        m_target[k] = tgt;
        m_ctr[k]    = 2;
      end
      if (mp && m_count < 64'hFFFF_FFFF) m_count++;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Compare DUT lookup outputs against the model for the current fetch_pc
  task automatic chk_lookup(input string nm);
    bit h;
    h = m_hit(fetch_pc);
    chk({nm, ".valid"},  {31'd0, predict_valid}, {31'd0, h});
    chk({nm, ".taken"},  {31'd0, predict_taken}, {31'd0, h && (m_ctr[m_idx(fetch_pc)] >= 2)});
    chk({nm, ".target"}, predict_target, h ? m_target[m_idx(fetch_pc)] : 32'd0);
  endtask

  // Drive one cycle starting from a negedge: check lookup, clock, check counter
  task automatic model_cycle(input string nm, input logic [31:0] fpc, input bit ue,
                             input logic [31:0] upc, input bit t,
                             input logic [31:0] tgt, input bit mp);
    fetch_pc = fpc; update_en = ue; update_pc = upc;
    update_taken = t; update_target = tgt; update_mispredict = mp;
    #1;
    chk_lookup(nm);
    @(posedge clk);
    model_update(ue, upc, t, tgt, mp);
    #1;
    chk({nm, ".count"}, mispredict_count, m_count[31:0]);
    @(negedge clk);
  endtask

  typedef struct {
    logic [31:0] fpc;
    bit          ue;
    logic [31:0] upc;
    bit          t;
    logic [31:0] tgt;
    bit          mp;
    bit          ev;
    bit          et;
    logic [31:0] etgt;
    logic [31:0] ecnt;
  } vec_t;

  vec_t vecs [25];

  task automatic set_vec(input int n, input logic [31:0] fpc, input bit ue,
                         input logic [31:0] upc, input bit t, input logic [31:0] tgt,
                         input bit mp, input bit ev, input bit et,
                         input logic [31:0] etgt, input logic [31:0] ecnt);
    vecs[n] = '{fpc, ue, upc, t, tgt, mp, ev, et, etgt, ecnt};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; fetch_pc = '0; update_en = 0; update_pc = '0;
    update_taken = 0; update_target = '0; update_mispredict = 0;
    model_reset();
    @(negedge clk);
    #1;
    chk("reset.valid", {31'd0, predict_valid}, 32'd0);
    chk("reset.count", mispredict_count, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Expected lookup values are the ones seen in the same cycle (pre-update)
    //        fpc       ue upc       t  tgt        mp  ev et etgt       ecnt
    set_vec(0,  32'h10, 1, 32'h10, 1, 32'h100, 0,  0, 0, 32'h0,   0); // collision
    set_vec(1,  32'h10, 0, 32'h0,  0, 32'h0,   0,  1, 1, 32'h100, 0);
    set_vec(2,  32'h50, 0, 32'h0,  0, 32'h0,   0,  0, 0, 32'h0,   0); // alias miss
    set_vec(3,  32'h10, 1, 32'h10, 0, 32'h0,   0,  1, 1, 32'h100, 0); // 10 -> 01
    set_vec(4,  32'h10, 1, 32'h10, 0, 32'h0,   0,  1, 0, 32'h100, 0); // 01 -> 00
    set_vec(5,  32'h10, 1, 32'h10, 1, 32'h100, 0,  1, 0, 32'h100, 0); // 00 -> 01
    set_vec(6,  32'h10, 1, 32'h10, 1, 32'h100, 0,  1, 0, 32'h100, 0); // 01 -> 10
    set_vec(7,  32'h10, 1, 32'h10, 1, 32'h100, 0,  1, 1, 32'h100, 0); // 10 -> 11
    set_vec(8,  32'h10, 1, 32'h10, 1, 32'h100, 0,  1, 1, 32'h100, 0); // 11 stays
    set_vec(9,  32'h10, 1, 32'h10, 0, 32'h0,   0,  1, 1, 32'h100, 0); // 11 -> 10
    set_vec(10, 32'h20, 1, 32'h20, 0, 32'h0,   0,  0, 0, 32'h0,   0); // NT miss
    set_vec(11, 32'h20, 0, 32'h0,  0, 32'h0,   0,  0, 0, 32'h0,   0);
    set_vec(12, 32'h30, 1, 32'h30, 1, 32'h300, 0,  0, 0, 32'h0,   0); // collision
    set_vec(13, 32'h30, 0, 32'h0,  0, 32'h0,   0,  1, 1, 32'h300, 0);
    set_vec(14, 32'h10, 1, 32'h50, 1, 32'h200, 0,  1, 1, 32'h100, 0); // evict
    set_vec(15, 32'h10, 0, 32'h0,  0, 32'h0,   0,  0, 0, 32'h0,   0);
    set_vec(16, 32'h50, 0, 32'h0,  0, 32'h0,   0,  1, 1, 32'h200, 0);
    set_vec(17, 32'h53, 0, 32'h0,  0, 32'h0,   0,  1, 1, 32'h200, 0); // pc[1:0] ignored
    set_vec(18, 32'h50, 1, 32'h24, 0, 32'h0,   1,  1, 1, 32'h200, 1);
    set_vec(19, 32'h50, 1, 32'h24, 0, 32'h0,   1,  1, 1, 32'h200, 2);
    set_vec(20, 32'h50, 0, 32'h24, 0, 32'h0,   1,  1, 1, 32'h200, 2); // no update_en
    set_vec(21, 32'h50, 1, 32'h24, 0, 32'h0,   1,  1, 1, 32'h200, 3);
    set_vec(22, 32'h50, 1, 32'h24, 0, 32'h0,   1,  1, 1, 32'h200, 4);
    set_vec(23, 32'h50, 0, 32'h24, 1, 32'h0,   1,  1, 1, 32'h200, 4); // no update_en
    set_vec(24, 32'h50, 1, 32'h24, 0, 32'h0,   1,  1, 1, 32'h200, 5);

    for (int n = 0; n < 25; n++) begin
      fetch_pc = vecs[n].fpc; update_en = vecs[n].ue; update_pc = vecs[n].upc;
      update_taken = vecs[n].t; update_target = vecs[n].tgt;
      update_mispredict = vecs[n].mp;
      #1;
      chk($sformatf("vec%0d.valid", n), {31'd0, predict_valid}, {31'd0, vecs[n].ev});
      chk($sformatf("vec%0d.taken", n), {31'd0, predict_taken}, {31'd0, vecs[n].et});
      chk($sformatf("vec%0d.target", n), predict_target, vecs[n].etgt);
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d.count", n), mispredict_count, vecs[n].ecnt);
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a cycle, with updates presented while held
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst.count", mispredict_count, 32'd0);
    update_en = 1; update_taken = 1; update_target = 32'h777; update_mispredict = 1;
    for (int a = 0; a <= 32'h3C; a += 4) begin
      fetch_pc = a;
      update_pc = a;
      #1;
      chk($sformatf("rst_sweep%0h.valid", a), {31'd0, predict_valid}, 32'd0);
      chk($sformatf("rst_sweep%0h.taken", a), {31'd0, predict_taken}, 32'd0);
      chk($sformatf("rst_sweep%0h.target", a), predict_target, 32'd0);
    end
    @(posedge clk);
    #1;
    chk("rst_hold.count", mispredict_count, 32'd0);
    fetch_pc = 32'h10;
    chk("rst_hold.valid", {31'd0, predict_valid}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    // First edge after deassertion accepts the update
    model_cycle("post_rst0", 32'h10, 1, 32'h10, 1, 32'h400, 1);
    model_cycle("post_rst1", 32'h10, 0, 32'h0, 0, 32'h0, 0);
    chk("post_rst.target", predict_target, 32'h400);

    // Randomized traffic over a small address pool so hits and aliases are frequent
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] fpc, upc;
      fpc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      upc = ($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3);
      if ($urandom_range(0, 15) == 0) fpc = $urandom;
      if ($urandom_range(0, 15) == 0) upc = $urandom;
      if ($urandom_range(0, 3) == 0) fpc = upc;
      model_cycle("rand", fpc, $urandom_range(0, 1) == 1, upc, $urandom_range(0, 1) == 1,
                  $urandom, $urandom_range(0, 1) == 1);
      if (c == 1500) do_reset();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
